uart_cmd_decoder: RTL
=====================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, register address width.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 SHALL have parameter GAP_CLKS, default 25000, max clocks between frame bytes (about 20 bit times at 12 MHz / 9600 baud).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port rx_valid, input, 1, one-cycle pulse from uart_rx per received byte.
REQ-007 SHALL have port rx_data, input, 8, received byte, valid when rx_valid=1.
REQ-008 SHALL have port tx_ready, input, 1, uart_tx idle and able to accept a byte.
REQ-009 SHALL have port tx_start, output, 1, one-cycle load strobe to uart_tx.
REQ-010 SHALL have port tx_data, output, 8, response byte to uart_tx.
REQ-011 SHALL have port reg_we, output, 1, one-cycle register write strobe.
REQ-012 SHALL have port reg_addr, output, ADDR_WIDTH, write address.
REQ-013 SHALL have port reg_wdata, output, 8, write data.
REQ-014 SHALL have port err_count, output, 8, saturating count of rejected frames.

Function
REQ-015 SHALL accept frames of four bytes: SYNC_BYTE, ADDR, DATA, CHK, where CHK = (ADDR + DATA) mod 256.
REQ-016 SHALL implement states IDLE, GET_ADDR, GET_DATA, GET_CHK, RESPOND.
REQ-017 SHALL, in IDLE, ignore every byte except SYNC_BYTE; on SYNC_BYTE it SHALL go to GET_ADDR.
REQ-018 SHALL advance GET_ADDR -> GET_DATA -> GET_CHK on each rx_valid, capturing the byte.
REQ-019 SHALL, on CHK byte, classify the frame as good if the checksum matches and ADDR bits [7:ADDR_WIDTH] are zero; otherwise bad.
REQ-020 SHALL, for a good frame, pulse reg_we on the cycle after the CHK rx_valid, with reg_addr/reg_wdata valid that cycle and held until the next write.
REQ-021 SHALL enter RESPOND with tx_data = 8'h06 (ACK) for a good frame, 8'h15 (NAK) for a bad frame.
REQ-022 SHALL, in RESPOND, assert tx_start for exactly one cycle on the first cycle tx_ready=1, then return to IDLE; tx_data SHALL be stable from RESPOND entry until after tx_start.
REQ-023 SHALL drop rx_valid bytes arriving while in RESPOND, including SYNC_BYTE.
REQ-024 SHALL abort to IDLE, with no write and no response, if GAP_CLKS clocks elapse in GET_ADDR/GET_DATA/GET_CHK without rx_valid; the gap counter SHALL restart on every accepted byte.
REQ-025 SHALL increment err_count on each NAK and each timeout, saturating at 255.
REQ-026 SHALL treat a SYNC_BYTE value inside a frame as ordinary data; no resynchronisation mid-frame.

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE, tx_start=0, tx_data=0, reg_we=0, reg_addr=0, reg_wdata=0, err_count=0, gap counter=0.
REQ-028 SHALL discard a partial frame or pending response when reset asserts mid-operation; no reg_we or tx_start follows reset release until a new complete frame arrives.

Structure
REQ-029 SHALL take the state encoding and the ACK (8'h06) and NAK (8'h15) constants from shared package uart_cmd_pkg.
REQ-030 SHALL implement the inter-byte timeout in sub-module uart_gap_timer (inputs clear/enable, output expired).

Verification
REQ-031 SHALL test a good frame: bytes A5 03 5C 5F -> one reg_we with addr 3, data 5C; then tx_start with tx_data 06; err_count 0.
REQ-032 SHALL test a bad checksum: bytes A5 03 5C 00 -> no reg_we; tx_data 15; err_count 1.
REQ-033 SHALL test an address range error: bytes A5 13 01 14 with ADDR_WIDTH=4 -> NAK 15; no write.
REQ-034 SHALL test a timeout: bytes A5 03, then a GAP_CLKS idle gap -> no tx_start; err_count increments; next good frame is accepted.
REQ-035 SHALL test noise and backpressure: bytes 00 FF A5 01 02 03 with tx_ready=0 for 500 clocks -> write addr 1, data 02; tx_start only after tx_ready rises; a byte sent during the wait is dropped.
REQ-036 SHALL test reset mid-frame: bytes A5 03, then rst_n pulse -> all outputs 0; then A5 02 10 12 -> write addr 2, data 10, ACK.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder: FSM states and response bytes.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StGetChk,
    StRespond
  } cmd_state_e;

  localparam logic [7:0] AckByte = 8'h06;
  localparam logic [7:0] NakByte = 8'h15;

  // Frame checksum: modulo-256 sum of address and data bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] addr, input logic [7:0] data);
    return addr + data;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles since the last clear and flags the
// cycle on which the GAP_CLKS-th consecutive idle cycle elapses.
module uart_gap_timer #(
  parameter int unsigned GAP_CLKS = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expiry is combinational so the owner can abort on the same edge; a clear wins.
  always_comb begin
    expired = enable && !clear && (cnt_q == CntW'(GAP_CLKS - 1));
    cnt_d   = cnt_q + CntW'(1);
    if (clear || !enable || expired) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: parses SYNC/ADDR/DATA/CHK frames, issues a register write for
// good frames and answers every completed frame with ACK or NAK on the UART transmitter.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned GAP_CLKS   = 25000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  tx_ready,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  reg_we,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic [7:0]            err_count
);

  cmd_state_e            state_q, state_d;
  logic [7:0]            addr_byte_q, addr_byte_d;
  logic [7:0]            data_byte_q, data_byte_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  reg_we_q, reg_we_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]            reg_wdata_q, reg_wdata_d;
  logic [7:0]            err_count_q, err_count_d;
  logic                  in_frame;
  logic                  gap_expired;
  logic                  frame_good;
  logic                  err_inc;

  assign in_frame = (state_q == StGetAddr) || (state_q == StGetData) || (state_q == StGetChk);

  uart_gap_timer #(
    .GAP_CLKS (GAP_CLKS)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx_valid),
    .enable  (in_frame),
    .expired (gap_expired)
  );

  // Good frame: checksum matches and the address fits in ADDR_WIDTH bits.
  assign frame_good = (frame_chk(addr_byte_q, data_byte_q) == rx_data) &&
                      ((addr_byte_q >> ADDR_WIDTH) == 8'd0);

  // Next-state and output decode for the frame FSM.
  always_comb begin
    state_d     = state_q;
    addr_byte_d = addr_byte_q;
    data_byte_d = data_byte_q;
    tx_data_d   = tx_data_q;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    err_inc     = 1'b0;
    tx_start    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = StGetAddr;
        end
      end
      StGetAddr: begin
        if (rx_valid) begin
          addr_byte_d = rx_data;
          state_d     = StGetData;
        end else if (gap_expired) begin
          state_d = StIdle;
          err_inc = 1'b1;
        end
      end
      StGetData: begin
        if (rx_valid) begin
          data_byte_d = rx_data;
          state_d     = StGetChk;
        end else if (gap_expired) begin
          state_d = StIdle;
          err_inc = 1'b1;
        end
      end
      StGetChk: begin
        if (rx_valid) begin
          state_d = StRespond;
          if (frame_good) begin
            reg_we_d    = 1'b1;
            reg_addr_d  = ADDR_WIDTH'(addr_byte_q);
            reg_wdata_d = data_byte_q;
            tx_data_d   = AckByte;
          end else begin
            tx_data_d = NakByte;
            err_inc   = 1'b1;
          end
        end else if (gap_expired) begin
          state_d = StIdle;
          err_inc = 1'b1;
        end
      end
      StRespond: begin
        // Incoming bytes are dropped here; the response leaves once the transmitter is free.
        if (tx_ready) begin
          tx_start = 1'b1;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    err_count_d = (err_inc && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_byte_q <= 8'd0;
      data_byte_q <= 8'd0;
      tx_data_q   <= 8'd0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'd0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      addr_byte_q <= addr_byte_d;
      data_byte_q <= data_byte_d;
      tx_data_q   <= tx_data_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      err_count_q <= err_count_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign err_count = err_count_q;

endmodule
